vga_board_capture: RTL and testbench
====================================

Name: vga_board_capture

Overview:
- Receive-side decoder for the on-chip VGA raster: tracks the pixel stream (vsync, blank/valid, 2-bit RGB) in the same clock domain as the VGA timing generator.
- Samples the colour at the centre of each of the 6x7 token cells, classifies it, and rebuilds the token array in the same encoding Ownership drives.
- Validates frame geometry, then publishes a board snapshot once per frame.
- Used as a built-in self-check and debug source (Top debug outputs) to confirm that what is displayed matches game state.

Parameters:
- H_ACTIVE, 640, valid pixels expected per line
- V_ACTIVE, 480, valid lines expected per frame
- X0, 80, x of column-0 cell centre
- PITCH_X, 80, x spacing between column centres
- Y0, 40, y of row-0 cell centre (row 0 = topmost)
- PITCH_Y, 80, y spacing between row centres

Ports:
- clock  input  1  system clock (pixel clock)
- reset  input  1  synchronous, active-high reset
- vsync  input  1  vertical sync, active low
- valid  input  1  visible-pixel flag; 1 = RGB is a live pixel
- red  input  2  pixel red
- green  input  2  pixel green
- blue  input  2  pixel blue
- board  output  2 x [6][7]  captured tokens; 00 empty, 01 player 1, 10 player 2
- frame_valid  output  1  one-cycle pulse: clean frame, board updated
- board_changed  output  1  one-cycle pulse, coincident with frame_valid, when the new board differs from the previous one
- frame_error  output  1  one-cycle pulse: frame rejected
- error_code  output  3  {bad_color, bad_width, bad_height}; held until the next frame_valid or frame_error
- frame_count  output  8  count of accepted frames; wraps 255 -> 0
- locked  output  1  1 once the first vsync falling edge has been seen

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Inputs are same-domain, so there is no synchronizer.
- One register each holds the previous valid and previous vsync for edge detection.
- Reset values: board all 00; frame_valid, board_changed and frame_error 0; error_code 000; frame_count 0; locked 0; all counters, masks and sticky flags 0; FSM in UNLOCKED.
- FSM UNLOCKED: ignore pixels. On vsync falling edge (prev=1, now=0), clear the counters, go to CAPTURE, and set locked=1. The partial first frame is never flagged.
- FSM CAPTURE, per cycle:
  - x_cnt (10b) = position of the current pixel. While valid=1, x_cnt increments after use.
  - Sample rule: valid=1, y_cnt = Y0+r*PITCH_Y (r 0..5) and x_cnt = X0+c*PITCH_X (c 0..6).
    - Classify RGB: 11/00/00 -> 01; 11/11/00 -> 10; 00/00/00 -> 00; anything else -> store 00 and set sticky bad_color.
    - Write capture[r][c] and set sample_mask bit r*7+c.
  - valid falling edge (end of line):
    - If x_cnt != H_ACTIVE, set sticky bad_width.
    - x_cnt <= 0; y_cnt <= y_cnt+1 (10b, saturate at 1023).
  - vsync falling edge (frame boundary), evaluated the next cycle with the updated counters:
    - bad_height = (y_cnt != V_ACTIVE) or (sample_mask != all 42 ones).
    - All flags clear: board <= capture; frame_valid=1; board_changed=(capture != old board); frame_count+1; error_code <= 000.
    - Otherwise: board holds; frame_error=1; error_code <= {bad_color, bad_width, bad_height}.
    - Then clear y_cnt, x_cnt, sample_mask and the sticky flags. Stay in CAPTURE.
- Simultaneous valid-fall and vsync-fall in one cycle: the line end is applied first and that line counts toward y_cnt before evaluation.
- vsync held low for multiple lines: only the falling edge acts.
- Lines with valid never high do not increment y_cnt.
- Output pulses last exactly one cycle. frame_valid and frame_error are mutually exclusive.
- Latency: outputs update 1 cycle after the vsync falling-edge cycle.
- Reset asserted mid-frame: all state returns to reset values; relock on the next vsync falling edge.

Test Plan:
- All-black 640x480 raster, 3 vsync falls -> first fall: locked=1, no pulse. Second and third falls: frame_valid pulse, board all 00, error_code 000, frame_count = 1 then 2.
- Red pixel at (80,40) and yellow pixel at (560,440) in an otherwise black frame -> board[0][0]=01, board[5][6]=10, rest 00. frame_valid and board_changed both pulse.
- Repeat the identical frame -> frame_valid=1, board_changed=0, board unchanged.
- One line with 639 valid pixels -> frame_error, error_code=010, board keeps the prior snapshot, frame_count unchanged.
- Frame of 479 lines -> error_code=001. Frame with blue (00/00/11) at (320,200) -> error_code=100.
- Reset pulsed mid-frame after a valid frame -> board 00, frame_count 0, locked 0. Next full frame gives no pulse; the following frame gives frame_valid.

Source files
------------

// File: rtl/vga_board_capture_if.sv
// Same-domain VGA pixel stream as seen by the board capture block.
interface vga_board_capture_if;
    logic       vsync;
    logic       valid;
    logic [1:0] red;
    logic [1:0] green;
    logic [1:0] blue;

    modport master (output vsync, valid, red, green, blue);
    modport slave  (input  vsync, valid, red, green, blue);
endinterface

// File: rtl/vga_board_capture.sv
// Rebuilds the 6x7 token board from the VGA raster by sampling cell centres and checking frame geometry.
// Results appear at the end of the cycle after the vsync-fall cycle; no backpressure, the raster never stalls.
module vga_board_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int X0       = 80,
    parameter int PITCH_X  = 80,
    parameter int Y0       = 40,
    parameter int PITCH_Y  = 80
) (
    input  logic                  clock,
    input  logic                  reset,
    vga_board_capture_if.slave    pix,
    output logic [5:0][6:0][1:0]  board,
    output logic                  frame_valid,
    output logic                  board_changed,
    output logic                  frame_error,
    output logic [2:0]            error_code,
    output logic [7:0]            frame_count,
    output logic                  locked
);
    localparam logic [9:0] H_LEN = 10'(H_ACTIVE);
    localparam logic [9:0] V_LEN = 10'(V_ACTIVE);
    localparam logic [9:0] Y_MAX = 10'd1023;

    typedef enum logic {UNLOCKED, CAPTURE} state_t;
    state_t state, state_next;

    logic                 prev_valid, prev_vsync, eval_pend;
    logic [9:0]           x_cnt, y_cnt;
    logic [5:0][6:0][1:0] capture;
    logic [5:0][6:0]      sample_mask;
    logic                 bad_color, bad_width, bad_height;

    logic       valid_fall, vsync_fall, lock_evt, frame_evt, sample;
    logic       row_hit, col_hit, token_bad;
    logic [2:0] row_idx, col_idx;
    logic [1:0] token;

    assign valid_fall = prev_valid & ~pix.valid;
    assign vsync_fall = prev_vsync & ~pix.vsync;
    assign bad_height = (y_cnt != V_LEN) || (sample_mask != '1);
    assign sample     = (state == CAPTURE) && pix.valid && row_hit && col_hit;

    always_ff @(posedge clock) begin
        if (reset) state <= UNLOCKED;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        lock_evt   = 1'b0;
        frame_evt  = 1'b0;
        case (state)
            UNLOCKED: if (vsync_fall) begin
                lock_evt   = 1'b1;
                state_next = CAPTURE;
            end
            CAPTURE:  frame_evt = vsync_fall;
        endcase
    end

    // Locate the cell whose centre is the current pixel, if any.
    always_comb begin
        row_hit = 1'b0;
        col_hit = 1'b0;
        row_idx = 3'd0;
        col_idx = 3'd0;
        for (int r = 0; r < 6; r++) begin
            if (y_cnt == 10'(Y0 + r * PITCH_Y)) begin
                row_hit = 1'b1;
                row_idx = 3'(r);
            end
        end
        for (int c = 0; c < 7; c++) begin
            if (x_cnt == 10'(X0 + c * PITCH_X)) begin
                col_hit = 1'b1;
                col_idx = 3'(c);
            end
        end
    end

    always_comb begin
        token     = 2'b00;
        token_bad = 1'b0;
        case ({pix.red, pix.green, pix.blue})
            6'b110000: token = 2'b01;
            6'b111100: token = 2'b10;
            6'b000000: token = 2'b00;
            default:   token_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_valid    <= 1'b0;
            prev_vsync    <= 1'b0;
            eval_pend     <= 1'b0;
            x_cnt         <= '0;
            y_cnt         <= '0;
            capture       <= '0;
            sample_mask   <= '0;
            bad_color     <= 1'b0;
            bad_width     <= 1'b0;
            board         <= '0;
            frame_valid   <= 1'b0;
            board_changed <= 1'b0;
            frame_error   <= 1'b0;
            error_code    <= '0;
            frame_count   <= '0;
            locked        <= 1'b0;
        end else begin
            prev_valid    <= pix.valid;
            prev_vsync    <= pix.vsync;
            eval_pend     <= frame_evt;
            frame_valid   <= 1'b0;
            board_changed <= 1'b0;
            frame_error   <= 1'b0;
            if (lock_evt) begin
                locked      <= 1'b1;
                x_cnt       <= '0;
                y_cnt       <= '0;
                sample_mask <= '0;
                bad_color   <= 1'b0;
                bad_width   <= 1'b0;
            end
            if (state == CAPTURE) begin
                if (pix.valid) x_cnt <= x_cnt + 10'd1;
                if (sample) begin
                    capture[row_idx][col_idx]     <= token;
                    sample_mask[row_idx][col_idx] <= 1'b1;
                    if (token_bad) bad_color <= 1'b1;
                end
                // Line end lands before the frame evaluation one cycle later.
                if (valid_fall) begin
                    if (x_cnt != H_LEN) bad_width <= 1'b1;
                    x_cnt <= '0;
                    if (y_cnt != Y_MAX) y_cnt <= y_cnt + 10'd1;
                end
                if (eval_pend) begin
                    if (!bad_color && !bad_width && !bad_height) begin
                        board         <= capture;
                        frame_valid   <= 1'b1;
                        board_changed <= (capture != board);
                        frame_count   <= frame_count + 8'd1;
                        error_code    <= 3'b000;
                    end else begin
                        frame_error <= 1'b1;
                        error_code  <= {bad_color, bad_width, bad_height};
                    end
                    x_cnt       <= '0;
                    y_cnt       <= '0;
                    sample_mask <= '0;
                    bad_color   <= 1'b0;
                    bad_width   <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_board_capture.sv
// Directed raster frames on a scaled geometry; a frame-level model predicts every output each cycle.
module tb_vga_board_capture;
    localparam int H  = 16;
    localparam int V  = 14;
    localparam int X0 = 2;
    localparam int PX = 2;
    localparam int Y0 = 1;
    localparam int PY = 2;
    localparam int HB = 4;
    localparam int VS_CYC = 6;

    logic clock = 1'b0;
    logic reset;
    vga_board_capture_if vif();

    logic [5:0][6:0][1:0] board;
    logic                 frame_valid, board_changed, frame_error, locked;
    logic [2:0]           error_code;
    logic [7:0]           frame_count;

    vga_board_capture #(
        .H_ACTIVE(H), .V_ACTIVE(V), .X0(X0), .PITCH_X(PX), .Y0(Y0), .PITCH_Y(PY)
    ) dut (
        .clock(clock), .reset(reset), .pix(vif),
        .board(board), .frame_valid(frame_valid), .board_changed(board_changed),
        .frame_error(frame_error), .error_code(error_code),
        .frame_count(frame_count), .locked(locked)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int misses  = 0;
    int neg_cnt = 0;
    bit chk_en  = 1'b0;

    logic [5:0] cell_rgb [6][7];

    // Frame verdict of the last frame sent, and the single pending model event.
    logic                 pf_ok;
    logic [2:0]           pf_code;
    logic [5:0][6:0][1:0] pf_cap;
    bit                   m_locked = 1'b0;
    int                   ev_at = -1;
    int                   ev_kind = 0;
    logic                 ev_ok;
    logic [2:0]           ev_code;
    logic [5:0][6:0][1:0] ev_cap;

    logic                 e_fv = 1'b0, e_fe = 1'b0, e_bc = 1'b0, e_locked = 1'b0;
    logic [2:0]           e_err = '0;
    logic [7:0]           e_count = '0;
    logic [5:0][6:0][1:0] e_board = '0;

    task automatic check(input string name, input logic [83:0] act, input logic [83:0] exp);
        vectors++;
        if (act !== exp) begin
            misses++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [2:0] classify(input logic [5:0] rgb);
        case (rgb)
            6'b110000: return 3'b001;
            6'b111100: return 3'b010;
            6'b000000: return 3'b000;
            default:   return 3'b100;
        endcase
    endfunction

    function automatic logic [5:0] pix_at(input int x, input int y);
        logic [5:0] v = 6'b0;
        if (x >= X0 && y >= Y0 && (x - X0) % PX == 0 && (y - Y0) % PY == 0)
            if ((y - Y0) / PY < 6 && (x - X0) / PX < 7)
                v = cell_rgb[(y - Y0) / PY][(x - X0) / PX];
        return v;
    endfunction

    task automatic compute_verdict(input int n_lines, input int short_line);
        logic bad_c, bad_w, bad_h;
        logic [2:0] cl;
        bad_w = (short_line >= 0 && short_line < n_lines);
        bad_h = (n_lines != V) || (Y0 + 5 * PY >= n_lines);
        bad_c = 1'b0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++) begin
                cl = classify(cell_rgb[r][c]);
                pf_cap[r][c] = cl[1:0];
                if (Y0 + r * PY < n_lines && cl[2]) bad_c = 1'b1;
            end
        pf_code = {bad_c, bad_w, bad_h};
        pf_ok   = (pf_code == 3'b000);
    endtask

    task automatic post(input int kind, input int delay);
        ev_kind = kind;
        ev_at   = neg_cnt + delay;
        ev_ok   = pf_ok;
        ev_code = pf_code;
        ev_cap  = pf_cap;
    endtask

    task automatic vs_pulse();
        vif.valid = 1'b0;
        {vif.red, vif.green, vif.blue} = 6'b0;
        vif.vsync = 1'b0;
        if (!m_locked) begin
            post(1, 2);
            m_locked = 1'b1;
        end else begin
            post(2, 3);
        end
        repeat (VS_CYC) step();
        vif.vsync = 1'b1;
        step();
    endtask

    task automatic send_lines(input int n_lines, input int short_line, input bit join_end);
        for (int y = 0; y < n_lines; y++) begin
            for (int x = 0; x < ((y == short_line) ? H - 1 : H); x++) begin
                vif.valid = 1'b1;
                {vif.red, vif.green, vif.blue} = pix_at(x, y);
                step();
            end
            if (!(join_end && y == n_lines - 1)) begin
                vif.valid = 1'b0;
                {vif.red, vif.green, vif.blue} = 6'b0;
                repeat (HB) step();
            end
        end
        compute_verdict(n_lines, short_line);
    endtask

    // Model update and per-cycle comparison, away from the active edge.
    initial begin
        forever begin
            @(negedge clock);
            neg_cnt++;
            e_fv = 1'b0;
            e_fe = 1'b0;
            e_bc = 1'b0;
            if (neg_cnt == ev_at) begin
                case (ev_kind)
                    1: e_locked = 1'b1;
                    2: if (ev_ok) begin
                        e_fv    = 1'b1;
                        e_bc    = (ev_cap != e_board);
                        e_board = ev_cap;
                        e_count = e_count + 8'd1;
                        e_err   = 3'b000;
                    end else begin
                        e_fe  = 1'b1;
                        e_err = ev_code;
                    end
                    3: begin
                        e_locked = 1'b0;
                        e_count  = '0;
                        e_board  = '0;
                        e_err    = '0;
                    end
                    default: ;
                endcase
            end
            if (chk_en) begin
                check("frame_valid", 84'(frame_valid), 84'(e_fv));
                check("frame_error", 84'(frame_error), 84'(e_fe));
                check("board_changed", 84'(board_changed), 84'(e_bc));
                check("locked", 84'(locked), 84'(e_locked));
                check("error_code", 84'(error_code), 84'(e_err));
                check("frame_count", 84'(frame_count), 84'(e_count));
                check("board", 84'(board), 84'(e_board));
            end
        end
    end

    initial begin
        reset = 1'b1;
        vif.vsync = 1'b1;
        vif.valid = 1'b0;
        {vif.red, vif.green, vif.blue} = 6'b0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++) cell_rgb[r][c] = 6'b0;
        pf_ok = 1'b0; pf_code = '0; pf_cap = '0;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk_en = 1'b1;
        check("lit_reset_locked", 84'(locked), 84'(0));
        check("lit_reset_count", 84'(frame_count), 84'(0));

        // All-black raster: lock, then two clean frames.
        send_lines(5, -1, 0);
        vs_pulse();
        check("lit_lock", 84'(locked), 84'(1));
        check("lit_lock_count", 84'(frame_count), 84'(0));
        send_lines(V, -1, 0);
        vs_pulse();
        check("lit_black1_count", 84'(frame_count), 84'(1));
        check("lit_black1_err", 84'(error_code), 84'(0));
        send_lines(V, -1, 0);
        vs_pulse();
        check("lit_black2_count", 84'(frame_count), 84'(2));

        // Red top-left, yellow bottom-right, twice.
        cell_rgb[0][0] = 6'b110000;
        cell_rgb[5][6] = 6'b111100;
        send_lines(V, -1, 0);
        vs_pulse();
        check("lit_red_cell", 84'(board[0][0]), 84'(2'b01));
        check("lit_yellow_cell", 84'(board[5][6]), 84'(2'b10));
        check("lit_other_cell", 84'(board[2][3]), 84'(2'b00));
        send_lines(V, -1, 0);
        vs_pulse();
        check("lit_repeat_count", 84'(frame_count), 84'(4));

        // Short line, short frame, illegal colour.
        send_lines(V, 5, 0);
        vs_pulse();
        check("lit_width_err", 84'(error_code), 84'(3'b010));
        check("lit_width_count", 84'(frame_count), 84'(4));
        check("lit_width_board", 84'(board[0][0]), 84'(2'b01));
        send_lines(V - 1, -1, 0);
        vs_pulse();
        check("lit_height_err", 84'(error_code), 84'(3'b001));
        cell_rgb[2][3] = 6'b000011;
        send_lines(V, -1, 0);
        vs_pulse();
        check("lit_color_err", 84'(error_code), 84'(3'b100));
        cell_rgb[2][3] = 6'b000000;

        // Last line ends in the same cycle as the vsync fall.
        cell_rgb[3][3] = 6'b111100;
        send_lines(V, -1, 1);
        vs_pulse();
        check("lit_join_count", 84'(frame_count), 84'(5));
        check("lit_join_cell", 84'(board[3][3]), 84'(2'b10));

        // Reset mid-frame, then relock and recapture.
        send_lines(4, -1, 0);
        vif.valid = 1'b1;
        step();
        vif.valid = 1'b0;
        reset = 1'b1;
        post(3, 2);
        step();
        step();
        reset = 1'b0;
        m_locked = 1'b0;
        step();
        check("lit_rst_locked", 84'(locked), 84'(0));
        check("lit_rst_count", 84'(frame_count), 84'(0));
        check("lit_rst_board", 84'(board), 84'(0));
        send_lines(V, -1, 0);
        vs_pulse();
        check("lit_relock_count", 84'(frame_count), 84'(0));
        send_lines(V, -1, 0);
        vs_pulse();
        check("lit_after_rst_count", 84'(frame_count), 84'(1));
        check("lit_after_rst_cell", 84'(board[5][6]), 84'(2'b10));

        repeat (4) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end
endmodule
